// File: rtl/sound_cond_pkg.sv
// -----------------------------------------------------------------------------
// sound_cond_pkg
// Shared types and default constants for the sound conditioning block.
//   state_t      : 2-bit FSM state encoding (IDLE, QUAL, ACTIVE, HOLD)
//   DEB_CYC_DEF  : default debounce length, 1 ms at 50 MHz
//   HOLD_CYC_DEF : default hold/stretch length, 1 s at 50 MHz
//   CNT_W_DEF    : default width of the shared debounce/hold counter
// -----------------------------------------------------------------------------
package sound_cond_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_QUAL   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int DEB_CYC_DEF  = 50000;
   localparam int HOLD_CYC_DEF = 50000000;
   localparam int CNT_W_DEF    = 26;

endpackage

// File: rtl/sound_cond_if.sv
// -----------------------------------------------------------------------------
// sound_cond_if
// Groups the sound-conditioner signals.
//   SOUNDRAW    : raw comparator output from the sound module (async, active-high)
//   SW6         : arm switch (async, 0 = disarmed)
//   SOUNDSENSOR : conditioned, registered sound level
//   EVTCNT      : 8-bit count of accepted sound events
// Modports:
//   slave  - the conditioner (consumes SOUNDRAW/SW6, drives outputs)
//   master - the environment driving the raw inputs
// -----------------------------------------------------------------------------
interface sound_cond_if;

   logic       SOUNDRAW;
   logic       SW6;
   logic       SOUNDSENSOR;
   logic [7:0] EVTCNT;

   modport slave (
      input  SOUNDRAW,
      input  SW6,
      output SOUNDSENSOR,
      output EVTCNT
   );

   modport master (
      output SOUNDRAW,
      output SW6,
      input  SOUNDSENSOR,
      input  EVTCNT
   );

endinterface

// File: rtl/sound_cond_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing an asynchronous level into the i_clk domain.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low clear of both flops
//   i_d     : asynchronous input level
//   o_q     : synchronized level, two edges behind i_d
// -----------------------------------------------------------------------------
module sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta_p0;
   logic r_sync_p1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta_p0 <= 1'b0;
         r_sync_p1 <= 1'b0;
      end else begin
         r_meta_p0 <= i_d;
         r_sync_p1 <= r_meta_p0;
      end
   end

   assign o_q = r_sync_p1;

endmodule

// File: rtl/sound_cond.sv
// -----------------------------------------------------------------------------
// sound_cond
// Debounces the raw sound-module output and stretches each accepted event so a
// slow (1 Hz) downstream timer stage is guaranteed to see it.
//
// Ports:
//   CLK  : system clock, the only clock
//   RSTN : asynchronous active-low reset
//   bus  : sound_cond_if.slave
//            SOUNDRAW (in), SW6 (in), SOUNDSENSOR (out), EVTCNT[7:0] (out)
// Parameters:
//   DEB_CYC  : synchronized-high cycles needed to accept an event (>= 2)
//   HOLD_CYC : stretch length after the input falls (>= 2)
//   CNT_W    : width of the shared debounce/hold counter
// Build option:
//   SOUND_COND_EVTCNT_EN - when defined, EVTCNT counts accepted events
//   (saturating at 255, cleared when disarmed); when undefined, EVTCNT is
//   tied to zero and no counter flops are built.
// -----------------------------------------------------------------------------
module sound_cond
   import sound_cond_pkg::*;
#(
   parameter int DEB_CYC  = DEB_CYC_DEF,
   parameter int HOLD_CYC = HOLD_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic         CLK,
   input  logic         RSTN,
   sound_cond_if.slave  bus
);

   // Parameter sanity: both terminal counts must fit in the counter.
   if (DEB_CYC < 2) begin : g_chk_deb_min
      $error("sound_cond: DEB_CYC must be at least 2");
   end
   if (HOLD_CYC < 2) begin : g_chk_hold_min
      $error("sound_cond: HOLD_CYC must be at least 2");
   end
   if ((64'(DEB_CYC) >> CNT_W) != 64'd0) begin : g_chk_deb_w
      $error("sound_cond: DEB_CYC not representable in CNT_W bits");
   end
   if ((64'(HOLD_CYC) >> CNT_W) != 64'd0) begin : g_chk_hold_w
      $error("sound_cond: HOLD_CYC not representable in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

   logic             w_snd_s;
   logic             w_arm_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_sensor;
   logic             w_sensor_nxt;

   // Input synchronization
   sync2 u_sync_snd (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_d     (bus.SOUNDRAW),
      .o_q     (w_snd_s)
   );

   sync2 u_sync_arm (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_d     (bus.SW6),
      .o_q     (w_arm_s)
   );

   // FSM next-state and counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_snd_s) begin
               w_state_nxt = ST_QUAL;
               w_cnt_nxt   = '0;
            end
         end
         ST_QUAL: begin
            if (!w_snd_s) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_nxt = ST_ACTIVE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!w_snd_s) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         ST_HOLD: begin
            // A returning input retriggers without counting a new event.
            if (w_snd_s) begin
               w_state_nxt = ST_ACTIVE;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Disarm wins over every other transition.
      if (!w_arm_s) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   // Output is registered from the next state so it tracks ACTIVE/HOLD exactly.
   assign w_sensor_nxt = (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_HOLD);

   // FSM state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_sensor <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_sensor <= w_sensor_nxt;
      end
   end

   assign bus.SOUNDSENSOR = r_sensor;

`ifdef SOUND_COND_EVTCNT_EN
   logic [7:0] r_evtcnt;
   logic       w_evt_inc;

   // Only the QUAL->ACTIVE edge counts; retriggers from HOLD do not.
   assign w_evt_inc = w_arm_s && (r_state == ST_QUAL) && w_snd_s && (r_cnt == DEB_LAST);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_evtcnt <= 8'd0;
      end else if (!w_arm_s) begin
         r_evtcnt <= 8'd0;
      end else if (w_evt_inc && (r_evtcnt != 8'hFF)) begin
         r_evtcnt <= r_evtcnt + 8'd1;
      end
   end

   assign bus.EVTCNT = r_evtcnt;
`else
   assign bus.EVTCNT = 8'd0;
`endif

endmodule

// File: tb/tb_sound_cond.sv
module tb_sound_cond;

   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int CW   = 8;
`ifdef SOUND_COND_EVTCNT_EN
   localparam bit EVT_EN = 1'b1;
`else
   localparam bit EVT_EN = 1'b0;
`endif

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;

   sound_cond_if bus ();

   sound_cond #(
      .DEB_CYC  (DEB),
      .HOLD_CYC (HOLD),
      .CNT_W    (CW)
   ) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: the inputs reach the decision logic two edges late;
   // an event is accepted after DEB+1 consecutive high observations starting
   // from rest, and released after HOLD+1 consecutive low observations.
   bit s1, s2, a1, a2, su, au;
   int m_hi, m_lo, m_evt;
   bit m_sens;

   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         s1 = 0; s2 = 0; a1 = 0; a2 = 0;
         m_hi = 0; m_lo = 0; m_evt = 0; m_sens = 0;
      end else begin
         su = s2; au = a2;
         s2 = s1; s1 = bus.SOUNDRAW;
         a2 = a1; a1 = bus.SW6;
         if (!au) begin
            m_sens = 0; m_hi = 0; m_lo = 0; m_evt = 0;
         end else if (!m_sens) begin
            m_hi = su ? m_hi + 1 : 0;
            if (m_hi == DEB + 1) begin
               m_sens = 1; m_lo = 0; m_hi = 0;
               if (m_evt < 255) m_evt = m_evt + 1;
            end
         end else begin
            m_lo = su ? 0 : m_lo + 1;
            if (m_lo == HOLD + 1) begin
               m_sens = 0; m_hi = 0; m_lo = 0;
            end
         end
      end
   end

   function automatic logic [7:0] exp_evt(input int n);
      return EVT_EN ? 8'(n) : 8'd0;
   endfunction

   // Bring the block to rest with a cleared event counter.
   task automatic disarm_rearm();
      bus.SOUNDRAW = 1'b0;
      bus.SW6      = 1'b0;
      repeat (3) @(negedge CLK);
      bus.SW6 = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_reset();
      bus.SOUNDRAW = 1'b1;
      bus.SW6      = 1'b1;
      RSTN         = 1'b0;
      #3;
      checks++;
      if (bus.SOUNDSENSOR !== 1'b0) begin
         failures++; $display("FAIL reset_sensor got=%b want=0", bus.SOUNDSENSOR);
      end
      checks++;
      if (bus.EVTCNT !== 8'd0) begin
         failures++; $display("FAIL reset_evtcnt got=%0d want=0", bus.EVTCNT);
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (bus.SOUNDSENSOR !== 1'b0) begin
         failures++; $display("FAIL reset_held_sensor got=%b want=0", bus.SOUNDSENSOR);
      end
      bus.SOUNDRAW = 1'b0;
      RSTN = 1'b1;
      repeat (10) @(negedge CLK);
      checks++;
      if (bus.SOUNDSENSOR !== 1'b0 || bus.EVTCNT !== 8'd0) begin
         failures++;
         $display("FAIL post_reset_idle got=%b/%0d want=0/0", bus.SOUNDSENSOR, bus.EVTCNT);
      end
   endtask

   task automatic test_glitch();
      disarm_rearm();
      bus.SOUNDRAW = 1'b1;
      repeat (3) @(negedge CLK);
      bus.SOUNDRAW = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         checks++;
         if (bus.SOUNDSENSOR !== 1'b0) begin
            failures++; $display("FAIL glitch_sensor cyc=%0d got=%b want=0", k, bus.SOUNDSENSOR);
         end
      end
      checks++;
      if (bus.EVTCNT !== 8'd0) begin
         failures++; $display("FAIL glitch_evtcnt got=%0d want=0", bus.EVTCNT);
      end
   endtask

   task automatic test_latency();
      logic want;
      disarm_rearm();
      bus.SOUNDRAW = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         want = (k >= DEB + 3);
         checks++;
         if (bus.SOUNDSENSOR !== want) begin
            failures++; $display("FAIL rise_edge edge=%0d got=%b want=%b", k, bus.SOUNDSENSOR, want);
         end
      end
      checks++;
      if (bus.EVTCNT !== exp_evt(1)) begin
         failures++; $display("FAIL rise_evtcnt got=%0d want=%0d", bus.EVTCNT, exp_evt(1));
      end
      bus.SOUNDRAW = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         want = (k < HOLD + 3);
         checks++;
         if (bus.SOUNDSENSOR !== want) begin
            failures++; $display("FAIL fall_edge edge=%0d got=%b want=%b", k, bus.SOUNDSENSOR, want);
         end
      end
      checks++;
      if (bus.EVTCNT !== exp_evt(1)) begin
         failures++; $display("FAIL fall_evtcnt got=%0d want=%0d", bus.EVTCNT, exp_evt(1));
      end
   endtask

   task automatic test_retrigger();
      disarm_rearm();
      bus.SOUNDRAW = 1'b1;
      repeat (10) @(negedge CLK);
      bus.SOUNDRAW = 1'b0;
      repeat (5) @(negedge CLK);
      bus.SOUNDRAW = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         checks++;
         if (bus.SOUNDSENSOR !== 1'b1) begin
            failures++; $display("FAIL retrig_sensor cyc=%0d got=%b want=1", k, bus.SOUNDSENSOR);
         end
      end
      checks++;
      if (bus.EVTCNT !== exp_evt(1)) begin
         failures++; $display("FAIL retrig_evtcnt got=%0d want=%0d", bus.EVTCNT, exp_evt(1));
      end
   endtask

   task automatic test_saturate();
      disarm_rearm();
      for (int p = 0; p < 300; p++) begin
         bus.SOUNDRAW = 1'b1;
         repeat (6) @(negedge CLK);
         bus.SOUNDRAW = 1'b0;
         repeat (14) @(negedge CLK);
      end
      checks++;
      if (bus.EVTCNT !== exp_evt(255)) begin
         failures++; $display("FAIL sat_evtcnt got=%0d want=%0d", bus.EVTCNT, exp_evt(255));
      end
      bus.SW6 = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.EVTCNT !== 8'd0 || bus.SOUNDSENSOR !== 1'b0) begin
         failures++;
         $display("FAIL disarm_clear got=%0d/%b want=0/0", bus.EVTCNT, bus.SOUNDSENSOR);
      end
      bus.SW6 = 1'b1;
   endtask

   task automatic test_async_reset();
      logic want;
      disarm_rearm();
      bus.SOUNDRAW = 1'b1;
      repeat (10) @(negedge CLK);
      bus.SOUNDRAW = 1'b0;
      repeat (6) @(negedge CLK);
      checks++;
      if (bus.SOUNDSENSOR !== 1'b1) begin
         failures++; $display("FAIL hold_before_reset got=%b want=1", bus.SOUNDSENSOR);
      end
      #2 RSTN = 1'b0;
      #1;
      checks++;
      if (bus.SOUNDSENSOR !== 1'b0 || bus.EVTCNT !== 8'd0) begin
         failures++;
         $display("FAIL async_clear got=%b/%0d want=0/0", bus.SOUNDSENSOR, bus.EVTCNT);
      end
      bus.SOUNDRAW = 1'b1;
      @(negedge CLK);
      RSTN = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLK);
         want = (k >= DEB + 3);
         checks++;
         if (bus.SOUNDSENSOR !== want) begin
            failures++; $display("FAIL requal_edge edge=%0d got=%b want=%b", k, bus.SOUNDSENSOR, want);
         end
      end
   endtask

   task automatic test_arm_race();
      disarm_rearm();
      bus.SOUNDRAW = 1'b1;
      repeat (4) @(negedge CLK);
      bus.SW6 = 1'b0;
      for (int k = 5; k <= 12; k++) begin
         @(negedge CLK);
         checks++;
         if (bus.SOUNDSENSOR !== 1'b0 || bus.EVTCNT !== 8'd0) begin
            failures++;
            $display("FAIL arm_race edge=%0d got=%b/%0d want=0/0", k, bus.SOUNDSENSOR, bus.EVTCNT);
         end
      end
      bus.SW6 = 1'b1;
      bus.SOUNDRAW = 1'b0;
   endtask

   task automatic test_random();
      int run;
      int disarm;
      run = 0;
      disarm = 0;
      disarm_rearm();
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLK);
         checks++;
         if (bus.SOUNDSENSOR !== m_sens || bus.EVTCNT !== exp_evt(m_evt)) begin
            failures++;
            $display("FAIL rand_model cyc=%0d got=%b/%0d want=%b/%0d",
                     c, bus.SOUNDSENSOR, bus.EVTCNT, m_sens, exp_evt(m_evt));
         end
         if (run == 0) begin
            bus.SOUNDRAW = ~bus.SOUNDRAW;
            run = (bus.SOUNDRAW && ($urandom_range(0, 1) == 0)) ?
                  $urandom_range(1, 5) : $urandom_range(1, 16);
         end else begin
            run--;
         end
         if (disarm > 0) begin
            disarm--;
            if (disarm == 0) bus.SW6 = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            bus.SW6 = 1'b0;
            disarm = $urandom_range(1, 4);
         end
      end
      bus.SW6 = 1'b1;
   endtask

   initial begin
      bus.SOUNDRAW = 1'b0;
      bus.SW6      = 1'b0;
      test_reset();
      test_glitch();
      test_latency();
      test_retrigger();
      test_saturate();
      test_async_reset();
      test_arm_race();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sound_cond.md
SOUND_COND -- requirements
Module: sound_cond

Interface
REQ-001 Parameter DEB_CYC, default 50000: consecutive synchronized-high CLK cycles required to accept a sound event (1 ms at 50 MHz).
REQ-002 Parameter HOLD_CYC, default 50000000: stretch length in CLK cycles after the input falls (1 s at 50 MHz), so the 1 Hz timer stage always samples the event.
REQ-003 Parameter CNT_W, default 26: width of the shared debounce/hold counter.
REQ-004 CLK  input  1  system clock; the block's only clock.
REQ-005 RSTN  input  1  reset; asynchronous, active-low.
REQ-006 SOUNDRAW  input  1  raw sound-module comparator output; asynchronous to CLK; active-high.
REQ-007 SW6  input  1  arm switch; asynchronous; 0 = disarmed.
REQ-008 SOUNDSENSOR  output  1  registered, conditioned sound level; feeds the countdown timer's SOUNDSENSOR input.
REQ-009 EVTCNT  output  8  count of accepted sound events.

Function
REQ-010 The block SHALL pass SOUNDRAW and SW6 each through a 2-flop synchronizer; only the synchronized values (snd_s, arm_s) reach the FSM.
REQ-011 The FSM SHALL have states IDLE, QUAL, ACTIVE and HOLD, and one counter cnt[CNT_W-1:0].
REQ-012 IDLE: snd_s=1 -> QUAL with cnt=0; otherwise stay in IDLE.
REQ-013 QUAL: snd_s=0 -> IDLE (glitch rejected, no count); snd_s=1 with cnt==DEB_CYC-1 -> ACTIVE; otherwise cnt+1.
REQ-014 ACTIVE: snd_s=0 -> HOLD with cnt=0; otherwise stay in ACTIVE.
REQ-015 HOLD: snd_s=1 -> ACTIVE (retrigger, no count); cnt==HOLD_CYC-1 -> IDLE; otherwise cnt+1.
REQ-016 SOUNDSENSOR SHALL be a register, 1 exactly while the state is ACTIVE or HOLD.
REQ-017 Latency: a SOUNDRAW rise held stable SHALL raise SOUNDSENSOR on exactly the (DEB_CYC+3)th CLK rising edge, counting the first edge that samples it high as edge 1.
REQ-018 SOUNDSENSOR SHALL fall on the (HOLD_CYC+3)th edge after the first edge that samples SOUNDRAW low, if SOUNDRAW stays low.
REQ-019 Each QUAL->ACTIVE transition SHALL increment EVTCNT by 1; the increment saturates at 255 and does not wrap.
REQ-020 arm_s=0 SHALL force the next state to IDLE, cnt=0, SOUNDSENSOR=0 and EVTCNT=0 on the next edge, overriding every other transition in the same cycle.
REQ-021 The synthesis flow SHALL reject DEB_CYC<2, HOLD_CYC<2, or either value not representable in CNT_W bits.

Reset
REQ-022 RSTN=0 SHALL asynchronously clear both synchronizers, state=IDLE, cnt=0, SOUNDSENSOR=0 and EVTCNT=0, including mid-QUAL or mid-HOLD.
REQ-023 After RSTN deasserts, the first transition SHALL occur no earlier than the third CLK edge, once the synchronizers have been refilled.

Configuration
REQ-024 Macro SOUND_COND_EVTCNT_EN: when defined, EVTCNT SHALL behave per REQ-019/REQ-020; when undefined, no counter flops SHALL exist and EVTCNT SHALL be tied to 8'd0, with all other behaviour unchanged.

Structure
REQ-025 Package sound_cond_pkg SHALL hold the state enum typedef (2 bits) and the default DEB_CYC, HOLD_CYC and CNT_W constants.
REQ-026 One sub-module, sync2 (a 2-flop synchronizer with async active-low clear), SHALL be instantiated twice.

Verification (DEB_CYC=4, HOLD_CYC=10, CNT_W=8)
REQ-027 SOUNDRAW high for 3 edges, then low -> SOUNDSENSOR stays 0 and EVTCNT stays 0.
REQ-028 SOUNDRAW rises and is held for 20 edges -> SOUNDSENSOR rises on edge 7 and EVTCNT=1; after SOUNDRAW falls, SOUNDSENSOR falls on the 13th edge.
REQ-029 SOUNDRAW re-rises 5 edges into HOLD -> SOUNDSENSOR stays 1 continuously and EVTCNT stays 1.
REQ-030 300 separate qualified pulses -> EVTCNT reads 255; then SW6=0 for 3 edges -> EVTCNT=0 and SOUNDSENSOR=0.
REQ-031 RSTN pulsed low mid-HOLD -> SOUNDSENSOR=0 immediately with no CLK edge; a held SOUNDRAW re-qualifies after DEB_CYC+3 edges.
REQ-032 SW6 goes low on the same edge QUAL would reach ACTIVE -> ends in IDLE, SOUNDSENSOR=0, EVTCNT=0.
